// File: rtl/io_bridge.sv
// CPU I/O bridge: decodes strobed accesses to a UART FIFO pair, control registers and a framebuffer.
// Optional stall timeout on UART waits is enabled by defining IO_BRIDGE_TIMEOUT_EN.
module io_bridge #(
    parameter int DATA_W   = 32,
    parameter int NUM_CTRL = 4,
    parameter int FB_AW    = 13,
    parameter int FB_DW    = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         io_read_strobe,
    input  logic                         io_write_strobe,
    input  logic [31:0]                  io_address,
    input  logic [DATA_W-1:0]            io_write_data,
    output logic [DATA_W-1:0]            io_read_data,
    output logic                         io_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_push,
    input  logic                         tx_full,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic [7:0]                   rx_count,
    output logic                         rx_pop,
    output logic [NUM_CTRL*DATA_W-1:0]   ctrl_regs,
    output logic [NUM_CTRL-1:0]          ctrl_wr,
    output logic                         fb_we,
    output logic [FB_AW-1:0]             fb_addr,
    output logic [FB_DW-1:0]             fb_din,
    output logic                         bus_err,
    output logic [31:0]                  err_addr
);

    localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

    typedef enum logic [1:0] {IDLE, TX_WAIT, RX_WAIT} state_t;

    state_t                             state_q, state_d;
    logic [NUM_CTRL-1:0][DATA_W-1:0]    ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]                ctrl_wr_q, ctrl_wr_d;
    logic [DATA_W-1:0]                  rdata_q, rdata_d;
    logic                               ready_q, ready_d;
    logic [7:0]                         tx_data_q, tx_data_d;
    logic                               tx_push_q, tx_push_d;
    logic                               rx_pop_q, rx_pop_d;
    logic                               fb_we_q, fb_we_d;
    logic [FB_AW-1:0]                   fb_addr_q, fb_addr_d;
    logic [FB_DW-1:0]                   fb_din_q, fb_din_d;
    logic                               err_q, err_d;
    logic [31:0]                        err_addr_q, err_addr_d;

`ifdef IO_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [31:0]                        pend_addr_q, pend_addr_d;
`endif

    logic              hit_data, hit_status, hit_fb, hit_ctrl;
    logic [IDX_W-1:0]  ctrl_idx;

    always_comb begin
        hit_data   = (io_address == 32'hD000_0000);
        hit_status = (io_address == 32'hD000_0004);
        hit_fb     = (io_address[31:24] == 8'hD1);
        hit_ctrl   = 1'b0;
        ctrl_idx   = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (io_address == 32'hD000_0008 + 32'(4 * i)) begin
                hit_ctrl = 1'b1;
                ctrl_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        ctrl_wr_d  = '0;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        tx_data_d  = tx_data_q;
        tx_push_d  = 1'b0;
        rx_pop_d   = 1'b0;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_din_d   = fb_din_q;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
`ifdef IO_BRIDGE_TIMEOUT_EN
        cnt_d       = '0;
        pend_addr_d = pend_addr_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef IO_BRIDGE_TIMEOUT_EN
                pend_addr_d = io_address;
`endif
                // Write wins when both strobes arrive together.
                if (io_write_strobe) begin
                    if (hit_data) begin
                        tx_data_d = io_write_data[7:0];
                        if (tx_full) begin
                            state_d = TX_WAIT;
                        end else begin
                            tx_push_d = 1'b1;
                            ready_d   = 1'b1;
                        end
                    end else if (hit_ctrl) begin
                        ctrl_d[ctrl_idx]    = io_write_data;
                        ctrl_wr_d[ctrl_idx] = 1'b1;
                        ready_d             = 1'b1;
                    end else if (hit_fb) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = io_address[FB_AW-1:0];
                        fb_din_d  = io_write_data[FB_DW-1:0];
                        ready_d   = 1'b1;
                    end else begin
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = '0;
                        err_addr_d = io_address;
                    end
                end else if (io_read_strobe) begin
                    if (hit_data) begin
                        if (rx_valid) begin
                            rx_pop_d      = 1'b1;
                            rdata_d       = '0;
                            rdata_d[7:0]  = rx_data;
                            ready_d       = 1'b1;
                        end else begin
                            state_d = RX_WAIT;
                        end
                    end else if (hit_status) begin
                        rdata_d      = '0;
                        rdata_d[8:0] = {tx_full, rx_count};
                        ready_d      = 1'b1;
                    end else if (hit_ctrl) begin
                        rdata_d = ctrl_q[ctrl_idx];
                        ready_d = 1'b1;
                    end else begin
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = '0;
                        err_addr_d = io_address;
                    end
                end
            end
            TX_WAIT: begin
                if (!tx_full) begin
                    tx_push_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            RX_WAIT: begin
                if (rx_valid) begin
                    rx_pop_d     = 1'b1;
                    rdata_d      = '0;
                    rdata_d[7:0] = rx_data;
                    ready_d      = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef IO_BRIDGE_TIMEOUT_EN
        // Still stalled after this cycle: count, or give up once the limit is reached.
        if (state_q != IDLE && state_d != IDLE) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d    = IDLE;
                ready_d    = 1'b1;
                err_d      = 1'b1;
                rdata_d    = '0;
                err_addr_d = pend_addr_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            ctrl_wr_q  <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_push_q  <= 1'b0;
            rx_pop_q   <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_din_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
            pend_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            ctrl_wr_q  <= ctrl_wr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            tx_data_q  <= tx_data_d;
            tx_push_q  <= tx_push_d;
            rx_pop_q   <= rx_pop_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_din_q   <= fb_din_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
`ifdef IO_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
`endif
        end
    end

    assign io_read_data = rdata_q;
    assign io_ready     = ready_q;
    assign tx_data      = tx_data_q;
    assign tx_push      = tx_push_q;
    assign rx_pop       = rx_pop_q;
    assign ctrl_regs    = ctrl_q;
    assign ctrl_wr      = ctrl_wr_q;
    assign fb_we        = fb_we_q;
    assign fb_addr      = fb_addr_q;
    assign fb_din       = fb_din_q;
    assign bus_err      = err_q;
    assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed scenarios plus randomized transactions
// scored against a transaction-level model (latency = 1 + stall cycles).
module tb_io_bridge;

    localparam int DATA_W   = 32;
    localparam int NUM_CTRL = 4;
    localparam int FB_AW    = 13;
    localparam int FB_DW    = 8;
    localparam int TIMEOUT  = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        io_read_strobe, io_write_strobe;
    logic [31:0]                 io_address;
    logic [DATA_W-1:0]           io_write_data, io_read_data;
    logic                        io_ready;
    logic [7:0]                  tx_data;
    logic                        tx_push, tx_full;
    logic [7:0]                  rx_data, rx_count;
    logic                        rx_valid, rx_pop;
    logic [NUM_CTRL*DATA_W-1:0]  ctrl_regs;
    logic [NUM_CTRL-1:0]         ctrl_wr;
    logic                        fb_we;
    logic [FB_AW-1:0]            fb_addr;
    logic [FB_DW-1:0]            fb_din;
    logic                        bus_err;
    logic [31:0]                 err_addr;

    io_bridge #(.DATA_W(DATA_W), .NUM_CTRL(NUM_CTRL), .FB_AW(FB_AW), .FB_DW(FB_DW),
                .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .io_read_strobe(io_read_strobe), .io_write_strobe(io_write_strobe),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count), .rx_pop(rx_pop),
        .ctrl_regs(ctrl_regs), .ctrl_wr(ctrl_wr),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0, n_ready = 0, n_push = 0, n_pop = 0, n_fb = 0, n_err = 0, n_cwr = 0;
    int ready_cyc = 0;
    logic [7:0]          last_tx;
    logic [FB_AW-1:0]    last_fb_addr;
    logic [FB_DW-1:0]    last_fb_din;
    logic [NUM_CTRL-1:0] last_cwr;

    always @(negedge clk) begin
        cyc++;
        if (io_ready)  begin n_ready++; ready_cyc = cyc; end
        if (tx_push)   begin n_push++; last_tx = tx_data; end
        if (rx_pop)    n_pop++;
        if (fb_we)     begin n_fb++; last_fb_addr = fb_addr; last_fb_din = fb_din; end
        if (bus_err)   n_err++;
        if (|ctrl_wr)  begin n_cwr++; last_cwr = ctrl_wr; end
    end

    // Reference model state.
    logic [31:0] m_ctrl [NUM_CTRL];
    logic [31:0] m_rdata;
    logic [31:0] m_err_addr;

    function automatic logic [NUM_CTRL*DATA_W-1:0] model_flat();
        logic [NUM_CTRL*DATA_W-1:0] f;
        for (int i = 0; i < NUM_CTRL; i++) f[i*DATA_W +: DATA_W] = m_ctrl[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CTRL; i++) m_ctrl[i] = '0;
        m_rdata    = '0;
        m_err_addr = '0;
    endtask

    task automatic idle_inputs();
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_address      = '0;
        io_write_data   = '0;
        tx_full         = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = '0;
        rx_count        = '0;
    endtask

    // One CPU transaction. full_n / rx_n: cycles (from the strobe cycle) that tx_full stays
    // high / rx_valid stays low. poke drives a stray write strobe two cycles in.
    task automatic txn(input string nm, input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] wd, input int full_n, input int rx_n,
                       input logic [7:0] rxd, input bit poke);
        int ci, s, wait_n, r0, p0, q0, f0, e0, c0;
        bit is_tx, is_rx, is_st, is_ctrl, is_fbw, is_err;
        logic [7:0] cnt;
        logic [31:0] status;
        ci = -1;
        for (int i = 0; i < NUM_CTRL; i++) if (addr == 32'hD000_0008 + 32'(4 * i)) ci = i;
        is_tx = 0; is_rx = 0; is_st = 0; is_fbw = 0;
        is_ctrl = (ci >= 0);
        if (wr) begin
            is_tx  = (addr == 32'hD000_0000);
            is_fbw = (addr[31:24] == 8'hD1);
            is_err = !(is_tx || is_ctrl || is_fbw);
        end else begin
            is_rx  = (addr == 32'hD000_0000);
            is_st  = (addr == 32'hD000_0004);
            is_err = !(is_rx || is_st || is_ctrl);
        end
        wait_n = is_tx ? full_n : (is_rx ? rx_n : 0);
        cnt    = 8'($urandom);
        status = {23'b0, (full_n > 0), cnt};
        r0 = n_ready; p0 = n_push; q0 = n_pop; f0 = n_fb; e0 = n_err; c0 = n_cwr;

        @(posedge clk); #1;
        s = cyc + 1;
        io_write_strobe = wr;
        io_read_strobe  = rd;
        io_address      = addr;
        io_write_data   = wd;
        tx_full         = (full_n > 0);
        rx_valid        = (rx_n == 0);
        rx_data         = rxd;
        rx_count        = cnt;
        for (int k = 1; k <= wait_n + 3; k++) begin
            @(posedge clk); #1;
            io_read_strobe  = 1'b0;
            io_write_strobe = (poke && k == 2);
            if (poke && k == 2) begin
                io_address    = 32'hD000_0008;
                io_write_data = 32'hFFFF_FFFF;
            end
            tx_full  = (k < full_n);
            rx_valid = (k >= rx_n);
        end
        tx_full  = 1'b0;
        rx_valid = 1'b0;

        if (wr && is_ctrl) m_ctrl[ci] = wd;
        if (!wr && is_rx)   m_rdata = {24'b0, rxd};
        if (!wr && is_st)   m_rdata = status;
        if (!wr && is_ctrl) m_rdata = m_ctrl[ci];
        if (is_err) begin m_rdata = '0; m_err_addr = addr; end

        checks++; if (n_ready - r0 !== 1) begin errors++;
            $display("FAIL %s ready_count got %0d want 1", nm, n_ready - r0); end
        checks++; if (ready_cyc !== s + 1 + wait_n) begin errors++;
            $display("FAIL %s ready_latency got %0d want %0d", nm, ready_cyc - s, 1 + wait_n); end
        checks++; if (n_push - p0 !== int'(is_tx)) begin errors++;
            $display("FAIL %s tx_push_count got %0d want %0d", nm, n_push - p0, is_tx); end
        if (is_tx) begin
            checks++; if (last_tx !== wd[7:0]) begin errors++;
                $display("FAIL %s tx_data got %h want %h", nm, last_tx, wd[7:0]); end
        end
        checks++; if (n_pop - q0 !== int'(is_rx)) begin errors++;
            $display("FAIL %s rx_pop_count got %0d want %0d", nm, n_pop - q0, is_rx); end
        checks++; if (n_fb - f0 !== int'(is_fbw)) begin errors++;
            $display("FAIL %s fb_we_count got %0d want %0d", nm, n_fb - f0, is_fbw); end
        if (is_fbw) begin
            checks++; if (last_fb_addr !== addr[FB_AW-1:0] || last_fb_din !== wd[FB_DW-1:0]) begin
                errors++; $display("FAIL %s fb_addr/din got %h/%h want %h/%h", nm, last_fb_addr,
                                   last_fb_din, addr[FB_AW-1:0], wd[FB_DW-1:0]); end
        end
        checks++; if (n_err - e0 !== int'(is_err)) begin errors++;
            $display("FAIL %s bus_err_count got %0d want %0d", nm, n_err - e0, is_err); end
        checks++; if (n_cwr - c0 !== int'(wr && is_ctrl)) begin errors++;
            $display("FAIL %s ctrl_wr_count got %0d want %0d", nm, n_cwr - c0, wr && is_ctrl); end
        if (wr && is_ctrl) begin
            checks++; if (last_cwr !== NUM_CTRL'(1 << ci)) begin errors++;
                $display("FAIL %s ctrl_wr got %b want %b", nm, last_cwr, NUM_CTRL'(1 << ci)); end
        end
        checks++; if (io_read_data !== m_rdata) begin errors++;
            $display("FAIL %s io_read_data got %h want %h", nm, io_read_data, m_rdata); end
        checks++; if (err_addr !== m_err_addr) begin errors++;
            $display("FAIL %s err_addr got %h want %h", nm, err_addr, m_err_addr); end
        checks++; if (ctrl_regs !== model_flat()) begin errors++;
            $display("FAIL %s ctrl_regs got %h want %h", nm, ctrl_regs, model_flat()); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if ({io_ready, tx_push, rx_pop, fb_we, bus_err, ctrl_wr} !== '0) begin errors++;
            $display("FAIL reset pulses got %b want 0", {io_ready, tx_push, rx_pop, fb_we, bus_err, ctrl_wr}); end
        checks++; if (io_read_data !== '0) begin errors++;
            $display("FAIL reset io_read_data got %h want 0", io_read_data); end
        checks++; if (ctrl_regs !== '0) begin errors++;
            $display("FAIL reset ctrl_regs got %h want 0", ctrl_regs); end
        checks++; if (err_addr !== '0) begin errors++;
            $display("FAIL reset err_addr got %h want 0", err_addr); end
    endtask

    task automatic test_ctrl();
        txn("ctrl_wr1", 1, 0, 32'hD000_000C, 32'h1234_5678, 0, 0, 8'h00, 0);
        txn("ctrl_rd1", 0, 1, 32'hD000_000C, 32'h0, 0, 0, 8'h00, 0);
        txn("ctrl_wr3", 1, 0, 32'hD000_0014, 32'hCAFE_F00D, 0, 0, 8'h00, 0);
        txn("ctrl_rd3", 0, 1, 32'hD000_0014, 32'h0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_fb();
        txn("fb_wr_top", 1, 0, 32'hD100_1FFF, 32'h0000_00A5, 0, 0, 8'h00, 0);
        txn("fb_rd_unmapped", 0, 1, 32'hD100_0010, 32'h0, 0, 0, 8'h00, 0);
    endtask

    task automatic test_uart();
        txn("tx_nostall", 1, 0, 32'hD000_0000, 32'h0000_0033, 0, 0, 8'h00, 0);
        txn("tx_stall5", 1, 0, 32'hD000_0000, 32'h0000_0041, 5, 0, 8'h00, 0);
        txn("rx_ready", 0, 1, 32'hD000_0000, 32'h0, 0, 0, 8'h5A, 0);
        txn("rx_wait3", 0, 1, 32'hD000_0000, 32'h0, 0, 3, 8'h7E, 0);
        txn("status", 0, 1, 32'hD000_0004, 32'h0, 1, 0, 8'h00, 0);
    endtask

    task automatic test_unmapped();
        txn("unmapped_rd", 0, 1, 32'hD000_0100, 32'h0, 0, 0, 8'h00, 0);
        txn("ctrl_past_end", 1, 0, 32'hD000_0018, 32'h1111_1111, 0, 0, 8'h00, 0);
        txn("status_wr", 1, 0, 32'hD000_0004, 32'h2222_2222, 0, 0, 8'h00, 0);
    endtask

    task automatic test_corner();
        txn("wr_and_rd", 1, 1, 32'hD000_0008, 32'h0BAD_BEEF, 0, 0, 8'h00, 0);
        txn("busy_ignored", 1, 0, 32'hD000_0000, 32'h0000_0055, 6, 0, 8'h00, 1);
        txn("rx_busy_ignored", 0, 1, 32'hD000_0000, 32'h0, 0, 5, 8'h99, 1);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        int kind;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 8);
            d    = $urandom;
            case (kind)
                0, 1: a = 32'hD000_0000;
                2:    a = 32'hD000_0004;
                3, 4: a = 32'hD000_0008 + 32'(4 * $urandom_range(0, NUM_CTRL - 1));
                5:    a = {8'hD1, 24'($urandom)};
                6:    a = {4'h3, 28'($urandom)};
                7:    a = 32'hD000_0008 + 32'(4 * $urandom_range(NUM_CTRL, NUM_CTRL + 8));
                default: a = {8'hD0, 24'($urandom_range(16'h100, 16'hFFFF))};
            endcase
            txn("random", $urandom_range(0, 1) == 1, 1'b1, a, d,
                $urandom_range(0, 4), $urandom_range(0, 4), 8'($urandom), 0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int r0, q0;
        r0 = n_ready; q0 = n_pop;
        @(posedge clk); #1;
        io_read_strobe = 1'b1; io_address = 32'hD000_0000; rx_valid = 1'b0;
        @(posedge clk); #1;
        io_read_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b1; rx_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        checks++; if (n_ready - r0 !== 0 || n_pop - q0 !== 0) begin errors++;
            $display("FAIL rst_mid_wait ready/pop got %0d/%0d want 0/0", n_ready - r0, n_pop - q0); end
        checks++; if (io_read_data !== '0 || ctrl_regs !== '0 || err_addr !== '0) begin errors++;
            $display("FAIL rst_mid_wait state got %h/%h/%h want zeros", io_read_data, ctrl_regs, err_addr); end
        txn("after_rst", 0, 1, 32'hD000_0000, 32'h0, 0, 0, 8'h3C, 0);
    endtask

`ifdef IO_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int r0, q0, e0, s;
        r0 = n_ready; q0 = n_pop; e0 = n_err;
        @(posedge clk); #1;
        s = cyc + 1;
        io_read_strobe = 1'b1; io_address = 32'hD000_0000; rx_valid = 1'b0;
        @(posedge clk); #1;
        io_read_strobe = 1'b0;
        repeat (TIMEOUT + 6) @(posedge clk);
        #1;
        m_rdata = '0; m_err_addr = 32'hD000_0000;
        checks++; if (n_ready - r0 !== 1 || ready_cyc !== s + 1 + TIMEOUT) begin errors++;
            $display("FAIL timeout ready got %0d at +%0d want 1 at +%0d", n_ready - r0, ready_cyc - s, 1 + TIMEOUT); end
        checks++; if (n_err - e0 !== 1 || n_pop - q0 !== 0) begin errors++;
            $display("FAIL timeout err/pop got %0d/%0d want 1/0", n_err - e0, n_pop - q0); end
        checks++; if (io_read_data !== m_rdata || err_addr !== m_err_addr) begin errors++;
            $display("FAIL timeout rdata/err_addr got %h/%h want %h/%h", io_read_data, err_addr, m_rdata, m_err_addr); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ctrl();
        test_fb();
        test_uart();
        test_unmapped();
        test_corner();
        test_random();
        test_reset_mid_wait();
`ifdef IO_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
